// File: rtl/clk_div_pkg.sv
// Shared types for the multi-channel clock divider.
package clk_div_pkg;

  // Default width of the divide-ratio and phase fields.
  localparam int DIV_W_DEF = 8;

  // Channel lifecycle.
  //   DISABLED : output held low.
  //   PENDING  : running on the old ratio while a new one waits for the wrap.
  //   RUN      : running on the current ratio.
  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    PENDING  = 2'd1,
    RUN      = 2'd2
  } ch_state_e;

  // One channel configuration at the default field width.
  typedef struct packed {
    logic [DIV_W_DEF-1:0] div;
    logic [DIV_W_DEF-1:0] phase;
  } ch_cfg_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, lifecycle FSM and registered outputs.
// A new ratio only takes effect at the wrap of the old one, or on sync_req,
// so the output never produces a runt pulse on reconfiguration.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
  input  logic             sync_req,
  output logic             div_clk,
  output logic             tick,
  output logic             locked,
  output ch_state_e        state
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] phase;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] pend_phase;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] app_div;
  logic [DIV_W-1:0] app_phase;
  logic             running;
  logic             wrap;
  logic             apply_now;
  logic             store_pend;

  // Counter status: low half of the period is cnt < div/2, wrap at div-1.
  always_comb begin
    half    = div >> 1;
    running = (state != DISABLED);
    wrap    = running && (cnt == div - ONE);
  end

  // Decide whether a configuration is applied this cycle and which one.
  // An incoming write is always the newest value, so it wins over pending.
  always_comb begin
    apply_now  = 1'b0;
    store_pend = 1'b0;
    app_div    = div;
    app_phase  = phase;
    case (state)
      DISABLED: begin
        if (cfg_we) begin
          apply_now = 1'b1;
          app_div   = cfg_div;
          app_phase = cfg_phase;
        end
      end
      PENDING: begin
        if (sync_req || wrap) begin
          apply_now = 1'b1;
          app_div   = cfg_we ? cfg_div   : pend_div;
          app_phase = cfg_we ? cfg_phase : pend_phase;
        end else if (cfg_we) begin
          store_pend = 1'b1;
        end
      end
      RUN: begin
        if (sync_req) begin
          apply_now = 1'b1;
          app_div   = cfg_we ? cfg_div   : div;
          app_phase = cfg_we ? cfg_phase : phase;
        end else if (cfg_we) begin
          store_pend = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Channel FSM, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DISABLED;
      cnt        <= '0;
      div        <= '0;
      phase      <= '0;
      pend_div   <= '0;
      pend_phase <= '0;
      div_clk    <= 1'b0;
      tick       <= 1'b0;
      locked     <= 1'b0;
    end else begin
      div_clk <= running && (cnt >= half);
      tick    <= running && (cnt == half);
      if (apply_now) begin
        div    <= app_div;
        phase  <= app_phase;
        locked <= 1'b0;
        if (app_div >= TWO) begin
          cnt   <= app_phase;
          state <= RUN;
        end else begin
          cnt   <= '0;
          state <= DISABLED;
        end
      end else begin
        if (running) begin
          cnt <= wrap ? '0 : cnt + ONE;
        end
        // Only a RUN wrap reaches here; a PENDING wrap always applies.
        if (wrap) begin
          locked <= 1'b1;
        end
        if (store_pend) begin
          pend_div   <= cfg_div;
          pend_phase <= cfg_phase;
          state      <= PENDING;
        end
      end
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH programmable clock dividers sharing one valid/ready config port.
// Handshake: a transfer happens on a cycle with cfg_valid && cfg_ready;
// cfg_ready is then low for exactly one cycle, and cfg_err pulses on the
// cycle after a transfer whose channel or phase is out of range.
module multi_clock_divider
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DIV_W  = DIV_W_DEF,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                master_clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_phase,
  output logic                cfg_err,
  input  logic                sync_req,
  output logic [NUM_CH-1:0]   div_clk,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   locked,
  output logic [2*NUM_CH-1:0] state_dbg
);

  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(NUM_CH);

  logic      xfer;
  logic      ch_bad;
  logic      phase_bad;
  logic      accept;
  ch_state_e ch_state [NUM_CH];

  // Request decode: a disabling ratio (N<2) accepts any phase.
  always_comb begin
    xfer      = cfg_valid && cfg_ready;
    ch_bad    = ({1'b0, cfg_ch} >= CH_LIMIT);
    phase_bad = (cfg_div >= DIV_W'(2)) && (cfg_phase >= cfg_div);
    accept    = xfer && !ch_bad && !phase_bad;
  end

  // Handshake and error pulse registers.
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= !xfer;
      cfg_err   <= xfer && (ch_bad || phase_bad);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we;
    assign we = accept && (cfg_ch == CH_W'(i));

    clk_div_channel #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk       (master_clk),
      .rst_n     (rst_n),
      .cfg_we    (we),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .sync_req  (sync_req),
      .div_clk   (div_clk[i]),
      .tick      (tick[i]),
      .locked    (locked[i]),
      .state     (ch_state[i])
    );

    assign state_dbg[2*i +: 2] = ch_state[i];
  end

endmodule
